mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU byte-addressed port and a word-wide RAM.
// Sub-word stores use read-modify-write; misaligned or illegal requests fault without touching RAM.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  done,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  // state   | meaning
  // IDLE    | waiting for a request
  // READ    | capture the addressed lane of ram_q into rdata
  // RMW_RD  | capture the whole word for a sub-word store merge
  // WRITE   | one-cycle RAM write
  // DONE    | done pulse, fault pulse if the request was rejected
  typedef enum logic [2:0] {S_IDLE, S_READ, S_RMW_RD, S_WRITE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              size_q, size_d;
  logic                    sign_q, sign_d;
  logic                    write_q, write_d;
  logic                    fault_q, fault_d;
  logic [DATA_WIDTH-1:0]   merge_q, merge_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    req;
  logic                    req_fault;
  logic [7:0]              byte_lane;
  logic [15:0]             half_lane;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    unused_addr_bits;

  // RAM only decodes ADDR_WIDTH word-address bits; higher CPU address bits wrap.
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  assign req = mem_read | mem_write;

  always_comb begin
    req_fault = 1'b0;
    case (size)
      2'b01:   req_fault = addr[0];
      2'b10:   req_fault = (addr[1:0] != 2'b00);
      2'b11:   req_fault = 1'b1;
      default: req_fault = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      write_q <= write_d;
      fault_q <= fault_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_fault)            state_d = S_DONE;
          else if (mem_write)       state_d = (size == 2'b10) ? S_WRITE : S_RMW_RD;
          else                      state_d = S_READ;
        end
      end
      S_READ:   state_d = S_DONE;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign byte_lane = ram_q[{addr_q[1:0], 3'b000} +: 8];
  assign half_lane = ram_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{(DATA_WIDTH-8){sign_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{(DATA_WIDTH-16){sign_q & half_lane[15]}}, half_lane};
      default: load_val = ram_q;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sign_d  = sign_q;
    write_d = write_q;
    fault_d = fault_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    if (state_q == S_IDLE && req) begin
      addr_d  = addr[ADDR_WIDTH+1:0];
      wdata_d = wdata;
      size_d  = size;
      sign_d  = sign_ext;
      write_d = mem_write;
      fault_d = req_fault;
    end
    if (state_q == S_RMW_RD) merge_d = ram_q;
    if (state_q == S_READ)   rdata_d = load_val;
  end

  always_comb begin
    stall  = ((state_q == S_IDLE) && req) || (state_q == S_READ) ||
             (state_q == S_RMW_RD) || (state_q == S_WRITE);
    done   = (state_q == S_DONE);
    fault  = (state_q == S_DONE) && fault_q;
    ram_we = (state_q == S_WRITE);
  end

  assign rdata     = rdata_q;
  assign ram_addr  = addr_q[ADDR_WIDTH+1:2];
  assign ram_wdata = (size_q == 2'b10) ? wdata_q : merged;

endmodule
